pkt_fifo_reader: RTL and testbench

Read-side packet engine for the switch's per-port byte FIFO. It pops bytes from the single-clock FIFO with a one-outstanding-per-cycle request stream, then parses length-prefixed packets. It forwards payload bytes to the egress port over a valid/ready interface with start/end-of-packet marking, and drops malformed packets with counted statistics. It sits between the FIFO read port and the egress transmit logic.

---
 rtl/pkt_fifo_reader.sv | 150 +++++++++++++++
 tb/tb_pkt_fifo_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_fifo_reader.sv
// Read-side packet engine: pops the per-port byte FIFO, strips length headers,
// forwards payload to egress through a 2-entry skid buffer and drops malformed packets.
module pkt_fifo_reader #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_req,
  input  logic [7:0]       fifo_rd_data,
  input  logic             fifo_rd_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_sop,
  output logic             tx_eop,
  output logic [7:0]       tx_len,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    S_HDR,
    S_PAY,
    S_DROP
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [7:0] len;
  } ent_t;

  state_t     r_state;
  logic [7:0] r_rem;
  logic [7:0] r_len;
  logic       r_first;
  logic       r_inflight;
  ent_t       r_e0;
  ent_t       r_e1;
  logic       r_v0;
  logic       r_v1;

  logic       w_pop;
  logic       w_push;
  ent_t       w_new;
  logic [2:0] w_need;

  assign w_pop  = r_v0 & tx_ready;
  assign w_push = fifo_rd_valid & (r_state == S_PAY);
  assign w_new  = {fifo_rd_data, r_first, (r_rem == 8'd1), r_len};

  // Credit rule: buffered + in-flight bytes, less this cycle's pop, must stay below 2.
  assign w_need      = 3'(r_v0) + 3'(r_v1) + 3'(r_inflight);
  assign fifo_rd_req = rst & ~fifo_empty & (w_need < (3'd2 + 3'(w_pop)));

  assign tx_valid = r_v0;
  assign tx_data  = r_e0.data;
  assign tx_sop   = r_e0.sop;
  assign tx_eop   = r_e0.eop;
  assign tx_len   = r_e0.len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_HDR;
      r_rem      <= 8'd0;
      r_len      <= 8'd0;
      r_first    <= 1'b0;
      r_inflight <= 1'b0;
      r_e0       <= '0;
      r_e1       <= '0;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      r_inflight <= fifo_rd_req;

      // Skid buffer: entry 0 is the head presented on tx_*.
      case ({w_push, w_pop})
        2'b01: begin
          r_e0 <= r_e1;
          r_v0 <= r_v1;
          r_v1 <= 1'b0;
        end
        2'b10: begin
          if (!r_v0) begin
            r_e0 <= w_new;
            r_v0 <= 1'b1;
          end else begin
            r_e1 <= w_new;
            r_v1 <= 1'b1;
          end
        end
        2'b11: begin
          if (r_v1) begin
            r_e0 <= r_e1;
            r_e1 <= w_new;
          end else begin
            r_e0 <= w_new;
          end
        end
        default: ;
      endcase

      if (w_pop && r_e0.eop) begin
        pkt_cnt <= pkt_cnt + CNT_W'(1);
      end

      // Parser advances once per returned byte.
      if (fifo_rd_valid) begin
        case (r_state)
          S_HDR: begin
            if (fifo_rd_data == 8'd0) begin
              drop_cnt <= drop_cnt + CNT_W'(1);
            end else if (fifo_rd_data > MAX_LEN_B) begin
              drop_cnt <= drop_cnt + CNT_W'(1);
              r_rem    <= fifo_rd_data;
              r_state  <= S_DROP;
            end else begin
              r_rem   <= fifo_rd_data;
              r_len   <= fifo_rd_data;
              r_first <= 1'b1;
              r_state <= S_PAY;
            end
          end
          S_PAY: begin
            r_first <= 1'b0;
            r_rem   <= r_rem - 8'd1;
            if (r_rem == 8'd1) begin
              r_state <= S_HDR;
            end
          end
          S_DROP: begin
            r_rem <= r_rem - 8'd1;
            if (r_rem == 8'd1) begin
              r_state <= S_HDR;
            end
          end
          default: r_state <= S_HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pkt_fifo_reader.sv
// Directed bench for pkt_fifo_reader with a behavioural byte FIFO and an
// expected-transfer scoreboard filled as packets are loaded.
module tb_pkt_fifo_reader;

  localparam int unsigned MAX_LEN = 64;
  localparam int unsigned CNT_W   = 4;

  logic             clk;
  logic             rst;
  logic             fifo_empty;
  logic             fifo_rd_req;
  logic [7:0]       fifo_rd_data;
  logic             fifo_rd_valid;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_sop;
  logic             tx_eop;
  logic [7:0]       tx_len;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] drop_cnt;

  pkt_fifo_reader #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_req  (fifo_rd_req),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_valid(fifo_rd_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_sop       (tx_sop),
    .tx_eop       (tx_eop),
    .tx_len       (tx_len),
    .pkt_cnt      (pkt_cnt),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-clock FIFO: pops on the request edge, data one cycle later.
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr        <= 8'd0;
      fifo_rd_valid <= 1'b0;
      fifo_rd_data  <= 8'd0;
    end else begin
      fifo_rd_valid <= fifo_rd_req && (rd_ptr != wr_ptr);
      if (fifo_rd_req && (rd_ptr != wr_ptr)) begin
        fifo_rd_data <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + 8'd1;
      end
    end
  end

  int          n_pass;
  int          n_total;
  int          cyc;
  int          hs_n;
  int          first_req;
  int          first_val;
  logic        uflow;
  logic [17:0] exp_q [$];
  int          hs_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: sample at the falling edge, return just after the next rising edge.
  task automatic cycle();
    logic [17:0] obs;
    logic [17:0] exp;
    @(negedge clk);
    cyc++;
    if (fifo_rd_req && fifo_empty) uflow = 1'b1;
    if (fifo_rd_req && first_req < 0) first_req = cyc;
    if (tx_valid && first_val < 0) first_val = cyc;
    if (tx_valid && tx_ready) begin
      obs = {tx_data, tx_sop, tx_eop, (tx_sop ? tx_len : 8'h00)};
      hs_cyc.push_back(cyc);
      hs_n++;
      chk("sb_has_expect", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        chk("tx_beat", 32'(obs), 32'(exp));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_pkt(input logic [7:0] len, input logic [7:0] first,
                          input logic [7:0] step, input bit fwd);
    logic [7:0] b;
    b = first;
    mem[wr_ptr] = len;
    wr_ptr++;
    for (int i = 0; i < int'(len); i++) begin
      mem[wr_ptr] = b;
      wr_ptr++;
      if (fwd) exp_q.push_back({b, (i == 0), (i == int'(len) - 1), ((i == 0) ? len : 8'h00)});
      b = b + step;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    tx_ready = 1'b0;
    wr_ptr   = 8'd0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    hs_cyc.delete();
    hs_n      = 0;
    uflow     = 1'b0;
    first_req = -1;
    first_val = -1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && rd_ptr == wr_ptr && !tx_valid && !fifo_rd_valid) && n < budget) begin
      cycle();
      n++;
    end
    repeat (4) cycle();
    chk({tag, "_drained"}, 32'(n < budget), 32'd1);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_no_underflow"}, 32'(uflow), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    n_pass   = 0;
    n_total  = 0;
    cyc      = 0;
    rst      = 1'b0;
    tx_ready = 1'b0;
    wr_ptr   = 8'd0;

    // Single packet with latency and throughput.
    do_reset();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_rd_req", 32'(fifo_rd_req), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    tx_ready = 1'b1;
    load_pkt(8'd3, 8'hA1, 8'h01, 1'b1);
    drain("single", 50);
    chk("single_latency", 32'(first_val - first_req), 32'd3);
    chk("single_beats", 32'(hs_cyc.size()), 32'd3);
    chk("single_back2back", 32'(hs_cyc[2] - hs_cyc[0]), 32'd2);
    chk("single_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Backpressure: head held, at most two bytes buffered, requests stop.
    do_reset();
    load_pkt(8'd3, 8'hA1, 8'h01, 1'b1);
    n = 0;
    while (!tx_valid && n < 20) begin
      cycle();
      n++;
    end
    chk("bp_valid_seen", 32'(tx_valid), 32'd1);
    repeat (5) begin
      cycle();
      chk("bp_hold_head", 32'({tx_valid, tx_data, tx_sop, tx_len}), 32'({1'b1, 8'hA1, 1'b1, 8'd3}));
    end
    chk("bp_req_stopped", 32'(fifo_rd_req), 32'd0);
    chk("bp_popped", 32'(rd_ptr), 32'd3);
    tx_ready = 1'b1;
    drain("bp", 50);
    chk("bp_beats", 32'(hs_cyc.size()), 32'd3);
    chk("bp_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Drops: zero length, oversize, then a legal single-byte packet.
    do_reset();
    tx_ready = 1'b1;
    load_pkt(8'd0, 8'h00, 8'h00, 1'b0);
    load_pkt(8'h41, 8'h55, 8'h00, 1'b0);
    load_pkt(8'd1, 8'h7E, 8'h00, 1'b1);
    drain("drop", 300);
    chk("drop_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("drop_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("drop_beats", 32'(hs_cyc.size()), 32'd1);

    // Back-to-back packets: one idle cycle between eop and next sop.
    do_reset();
    tx_ready = 1'b1;
    load_pkt(8'd2, 8'h11, 8'h11, 1'b1);
    load_pkt(8'd2, 8'h33, 8'h11, 1'b1);
    drain("b2b", 50);
    chk("b2b_beats", 32'(hs_cyc.size()), 32'd4);
    chk("b2b_gap0", 32'(hs_cyc[1] - hs_cyc[0]), 32'd1);
    chk("b2b_gap1", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
    chk("b2b_gap2", 32'(hs_cyc[3] - hs_cyc[2]), 32'd1);
    chk("b2b_pkt_cnt", 32'(pkt_cnt), 32'd2);

    // Reset in the middle of a packet.
    do_reset();
    tx_ready = 1'b1;
    load_pkt(8'd5, 8'hB1, 8'h01, 1'b1);
    n = 0;
    while (hs_n < 2 && n < 30) begin
      cycle();
      n++;
    end
    chk("mid_two_beats", 32'(hs_n), 32'd2);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", 32'({tx_valid, tx_data, tx_sop, tx_eop, tx_len}), 32'd0);
    chk("mid_rst_req", 32'(fifo_rd_req), 32'd0);
    chk("mid_rst_cnts", 32'({pkt_cnt, drop_cnt}), 32'd0);
    exp_q.delete();
    wr_ptr = 8'd0;
    @(posedge clk);
    #1;
    chk("mid_rst_hold", 32'({fifo_rd_req, tx_valid}), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    hs_cyc.delete();
    uflow = 1'b0;
    load_pkt(8'd1, 8'h99, 8'h00, 1'b1);
    drain("mid_fresh", 50);
    chk("mid_fresh_beats", 32'(hs_cyc.size()), 32'd1);
    chk("mid_fresh_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("mid_fresh_drop_cnt", 32'(drop_cnt), 32'd0);

    // Counter wrap at 4 bits: 17 packets leave the count at 1.
    do_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 17; i++) load_pkt(8'd1, 8'(i + 8'h20), 8'h00, 1'b1);
    drain("wrap", 300);
    chk("wrap_beats", 32'(hs_cyc.size()), 32'd17);
    chk("wrap_pkt_cnt", 32'(pkt_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
